io_port_responder: RTL and testbench
====================================

IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 The block SHALL have parameter IO_BASE, default 32'h1001_0100, giving the byte base address of a 256-byte I/O window.
REQ-002 The block SHALL have parameter EDGE_CNT_W, default 16, giving the edge-counter width (1..32).
REQ-003 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port MemWrite, input, 1 bit: processor data-bus write strobe.
REQ-006 The block SHALL have port MemRead, input, 1 bit: processor data-bus read strobe.
REQ-007 The block SHALL have port Address, input, 32 bits: processor byte address.
REQ-008 The block SHALL have port WriteData, input, 32 bits: processor store data.
REQ-009 The block SHALL have port PortIn, input, 8 bits: asynchronous external input pins.
REQ-010 The block SHALL have port ReadData, output, 32 bits: load data returned to the processor.
REQ-011 The block SHALL have port Hit, output, 1 bit: Address lies in the I/O window and is word-aligned.
REQ-012 The block SHALL have port PortOut, output, 32 bits: registered external output port.
REQ-013 The block SHALL have port IrqOut, output, 1 bit: registered change interrupt.

Function
REQ-014 Hit SHALL be combinational: Address[31:8]==IO_BASE[31:8] and Address[1:0]==0.
REQ-015 Register map by offset Address[7:0] SHALL be:
- 0x00 PORTOUT (RW)
- 0x04 PORTIN (RO, zero-extended synchronized pins)
- 0x08 STATUS (bit0 CHG, write-1-to-clear)
- 0x0C CTRL (bit0 IRQ_EN, RW; other bits read 0)
- 0x10 EDGECNT (RO value; any write clears it)
REQ-016 ReadData SHALL be combinational, zero-latency: the selected register when MemRead&Hit, else 32'h0; unmapped offsets SHALL read 0.
REQ-017 Writes SHALL take effect at the rising clk edge where MemWrite&Hit; writes to unmapped offsets or PORTIN SHALL be ignored.
REQ-018 MemRead and MemWrite asserted together SHALL perform the write; ReadData SHALL show the pre-write value in that cycle.
REQ-019 PortIn SHALL pass a 2-flop synchronizer; PORTIN reads the second stage (2-cycle latency from pin to register view).
REQ-020 A third stage SHALL hold the previous synchronized value; any bit difference between stages 2 and 3 SHALL set CHG on the next edge.
REQ-021 When a CHG set event and a W1C of CHG coincide, set SHALL win.
REQ-022 EDGECNT SHALL increment by 1 on each synchronized 0->1 transition of PortIn[0], wrapping from all-ones to 0.
REQ-023 When a write to EDGECNT and an increment coincide, EDGECNT SHALL become 0 (clear wins).
REQ-024 IrqOut SHALL be a register equal to CHG & IRQ_EN, updated one cycle after either changes.
REQ-025 No state change SHALL occur when Hit=0, irrespective of MemWrite.

Reset
REQ-026 While reset=0: PortOut, CHG, IRQ_EN, EDGECNT, IrqOut, and all synchronizer stages SHALL be 0, asynchronously.
REQ-027 The first synchronized value after reset release SHALL be compared against 0, so a pin high at release sets CHG and counts one PortIn[0] edge.
REQ-028 Reset asserted mid-operation SHALL abort any pending update; no write from the reset cycle survives.

Configuration
REQ-029 Macro IO_EDGE_COUNTER_EN defined: the EDGECNT register and its logic SHALL be present per REQ-022/023.
REQ-030 Macro IO_EDGE_COUNTER_EN undefined: offset 0x10 SHALL read 0, writes to it SHALL be ignored, and no counter flops SHALL be synthesized.

Structure
REQ-031 Package io_map_pkg SHALL hold the offset constants (OFF_PORTOUT, OFF_PORTIN, OFF_STATUS, OFF_CTRL, OFF_EDGECNT) and the STATUS/CTRL bit indices.
REQ-032 Sub-module port_in_sync SHALL implement the 3-stage synchronizer, change detect, and bit-0 rising-edge pulse.

Verification
REQ-033 Scenario: write 32'hA5A5_0F0F to 0x1001_0100, then read it back -> PortOut=32'hA5A5_0F0F the next cycle; ReadData=32'hA5A5_0F0F.
REQ-034 Scenario: PortIn 8'h00->8'h81 -> PORTIN reads 32'h81 after 2 edges; CHG=1 after 3 edges; with IRQ_EN=1, IrqOut=1 one cycle later; W1C 0x1 to STATUS -> CHG=0 and IrqOut=0 the cycle after.
REQ-035 Scenario: toggle PortIn[0] 5 times -> EDGECNT=5; set EDGECNT to all-ones, then apply one more edge -> EDGECNT=0; a write coinciding with an edge -> EDGECNT=0.
REQ-036 Scenario: write to 0x1001_0102 (misaligned) and to 0x1001_0200 (out of window) -> Hit=0 and no register change; read at offset 0x20 -> ReadData=0 with Hit=1.
REQ-037 Scenario: reset pulled low between edges with PortOut=32'hFF -> PortOut=0 immediately; a W1C coinciding with a CHG set event -> CHG stays 1.
REQ-038 Scenario: build without IO_EDGE_COUNTER_EN -> read at 0x10 returns 0 after 3 PortIn[0] edges.

Source files
------------

// File: rtl/io_map_pkg.sv
// io_map_pkg: register offsets, bit indices and a read-formatting helper for io_port_responder
package io_map_pkg;

    localparam logic [7:0] OFF_PORTOUT = 8'h00;
    localparam logic [7:0] OFF_PORTIN  = 8'h04;
    localparam logic [7:0] OFF_STATUS  = 8'h08;
    localparam logic [7:0] OFF_CTRL    = 8'h0C;
    localparam logic [7:0] OFF_EDGECNT = 8'h10;

    localparam int STATUS_CHG_BIT = 0;
    localparam int CTRL_IRQEN_BIT = 0;

    // place a single flag at its bit position inside an otherwise-zero read word
    function automatic logic [31:0] bitWord(input logic flag, input int idx);
        bitWord = 32'(flag) << idx;
    endfunction

endpackage

// File: rtl/port_in_sync.sv
// port_in_sync: 3-stage PortIn synchronizer with change detect and bit-0 rise pulse
// Build option: the rise0 output exists only when IO_EDGE_COUNTER_EN is defined.
module port_in_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pinIn,
    output logic [7:0] syncVal,
    output logic       changed
`ifdef IO_EDGE_COUNTER_EN
    ,
    output logic       rise0
`endif
);

    logic [7:0] meta;
    logic [7:0] stable;
    logic [7:0] prev;

    // two metastability stages plus a history stage; clearing all three makes the first value compare against 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta   <= '0;
            stable <= '0;
            prev   <= '0;
        end else begin
            meta   <= pinIn;
            stable <= meta;
            prev   <= stable;
        end
    end

    assign syncVal = stable;
    assign changed = |(stable ^ prev);

`ifdef IO_EDGE_COUNTER_EN
    assign rise0 = stable[0] & ~prev[0];
`endif

endmodule

// File: rtl/io_port_responder.sv
// io_port_responder: memory-mapped I/O window with output port, synchronized input port, change IRQ and edge counter
// Build option: define IO_EDGE_COUNTER_EN to include the EDGECNT register; otherwise offset 0x10 reads 0 and holds no flops.
module io_port_responder
    import io_map_pkg::*;
#(
    parameter logic [31:0] IO_BASE    = 32'h1001_0100,
    parameter int          EDGE_CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut,
    output logic        IrqOut
);

    logic [7:0]            offset;
    logic [7:0]            syncIn;
    logic                  changed;
    logic                  wrEn;
    logic                  chg;
    logic                  irqEn;
    logic [EDGE_CNT_W-1:0] edgeCnt;

    assign Hit    = (Address[31:8] == IO_BASE[31:8]) && (Address[1:0] == 2'b00);
    assign offset = Address[7:0];
    assign wrEn   = MemWrite & Hit;

`ifdef IO_EDGE_COUNTER_EN
    logic rise0;
`endif

    port_in_sync uSync (
        .clk     (clk),
        .reset   (reset),
        .pinIn   (PortIn),
        .syncVal (syncIn),
        .changed (changed)
`ifdef IO_EDGE_COUNTER_EN
        ,
        .rise0   (rise0)
`endif
    );

    // control/status registers; a fresh change event outranks a coincident write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PortOut <= '0;
            chg     <= 1'b0;
            irqEn   <= 1'b0;
            IrqOut  <= 1'b0;
        end else begin
            if (wrEn && offset == OFF_PORTOUT)
                PortOut <= WriteData;
            if (wrEn && offset == OFF_CTRL)
                irqEn <= WriteData[CTRL_IRQEN_BIT];
            if (changed)
                chg <= 1'b1;
            else if (wrEn && offset == OFF_STATUS && WriteData[STATUS_CHG_BIT])
                chg <= 1'b0;
            IrqOut <= chg & irqEn;
        end
    end

`ifdef IO_EDGE_COUNTER_EN
    // any write clears the counter and beats a coincident edge; otherwise count synchronized rises, wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            edgeCnt <= '0;
        else
            edgeCnt <= (wrEn && offset == OFF_EDGECNT) ? '0 : rise0 ? edgeCnt + EDGE_CNT_W'(1) : edgeCnt;
    end
`else
    assign edgeCnt = '0;
`endif

    // zero-latency read mux; anything not a mapped read returns 0
    always_comb begin
        ReadData = '0;
        if (MemRead && Hit) begin
            case (offset)
                OFF_PORTOUT: ReadData = PortOut;
                OFF_PORTIN:  ReadData = {24'h0, syncIn};
                OFF_STATUS:  ReadData = bitWord(chg, STATUS_CHG_BIT);
                OFF_CTRL:    ReadData = bitWord(irqEn, CTRL_IRQEN_BIT);
                OFF_EDGECNT: ReadData = 32'(edgeCnt);
                default:     ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: scoreboard bench for io_port_responder against a pin-history reference model
module tb_io_port_responder;

    localparam logic [31:0] BASE = 32'h1001_0100;
    localparam int          CW   = 4;
`ifdef IO_EDGE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        IrqOut;

    io_port_responder #(.IO_BASE(BASE), .EDGE_CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Address   (Address),
        .WriteData (WriteData),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortOut   (PortOut),
        .IrqOut    (IrqOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        hit;
    } exp_t;

    exp_t sb[$];
    int   passCnt = 0;
    int   totalCnt = 0;

    // reference model state: register contents plus the last three pin values seen at clock edges
    logic [31:0] mPortOut;
    logic        mChg;
    logic        mIrqEn;
    logic        mIrq;
    int          mCnt;
    logic [7:0]  hist [3];
    logic [7:0]  pinV;
    logic [31:0] offs [6] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic inWin(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd256) && ((a % 4) == 0);
    endfunction

    // a register read sees the pin value from two edges back
    function automatic logic [31:0] rdExp(input logic rd, input logic [31:0] a);
        if (!rd || !inWin(a)) return 32'h0;
        case (a - BASE)
            0:       return mPortOut;
            4:       return 32'(hist[1]);
            8:       return 32'(mChg);
            12:      return 32'(mIrqEn);
            16:      return CNT_EN ? 32'(mCnt) : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        mPortOut = 0;
        mChg = 0;
        mIrqEn = 0;
        mIrq = 0;
        mCnt = 0;
        hist[0] = 0;
        hist[1] = 0;
        hist[2] = 0;
    endtask

    task automatic modelEdge();
        logic [31:0] off;
        logic wr, setEv, rise, oldIrq;
        if (!reset) return;
        wr = MemWrite && inWin(Address);
        off = Address - BASE;
        setEv = hist[1] != hist[2];
        rise = hist[1][0] && !hist[2][0];
        oldIrq = mChg && mIrqEn;
        if (wr && off == 0) mPortOut = WriteData;
        if (wr && off == 12) mIrqEn = WriteData[0];
        if (setEv) mChg = 1;
        else if (wr && off == 8 && WriteData[0]) mChg = 0;
        if (wr && off == 16) mCnt = 0;
        else if (rise) mCnt = (mCnt + 1) % (1 << CW);
        mIrq = oldIrq;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = PortIn;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        MemWrite = wr;
        MemRead = rd;
        Address = a;
        WriteData = wd;
        PortIn = pinV;
        if (wr || rd) begin
            e.rdata = rdExp(rd, a);
            e.hit = inWin(a);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic cycle(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd);
        drive(wr, rd, a, wd);
        tick();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, BASE, 32'h0);
    endtask

    task automatic readConst(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, 1'b1, a, 32'h0);
        #1;
        chk(name, ReadData, exp);
        tick();
    endtask

    task automatic toggle0(input int n);
        for (int i = 0; i < n; i++) begin
            pinV[0] = 1'b0;
            idle();
            idle();
            pinV[0] = 1'b1;
            idle();
            idle();
        end
        repeat (3) idle();
    endtask

    // monitor: every bus access is matched against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (MemRead || MemWrite) begin
            if (sb.size() == 0) begin
                totalCnt++;
                $display("FAIL sb_underflow: got a bus access with no expected entry");
            end else begin
                e = sb.pop_front();
                chk("readdata", ReadData, e.rdata);
                chk("hit", 32'(Hit), 32'(e.hit));
            end
        end
        chk("portout", PortOut, mPortOut);
        chk("irqout", 32'(IrqOut), 32'(mIrq));
    end

    initial begin
        modelReset();
        pinV = 8'h00;
        reset = 1'b0;
        MemWrite = 1'b0;
        MemRead = 1'b0;
        Address = 32'h0;
        WriteData = 32'h0;
        PortIn = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_portout", PortOut, 32'h0);
        chk("rst_irqout", 32'(IrqOut), 32'h0);
        chk("rst_readdata", ReadData, 32'h0);
        reset = 1'b1;

        cycle(1'b1, 1'b0, BASE, 32'hA5A5_0F0F);
        chk("portout_write", PortOut, 32'hA5A5_0F0F);
        readConst("portout_read", BASE, 32'hA5A5_0F0F);

        cycle(1'b1, 1'b0, BASE + 12, 32'h1);
        pinV = 8'h81;
        idle();
        idle();
        readConst("portin_sync", BASE + 4, 32'h81);
        readConst("chg_set", BASE + 8, 32'h1);
        chk("irq_set", 32'(IrqOut), 32'h1);
        cycle(1'b1, 1'b0, BASE + 8, 32'h1);
        readConst("chg_w1c", BASE + 8, 32'h0);
        chk("irq_clear", 32'(IrqOut), 32'h0);

        cycle(1'b1, 1'b0, BASE + 16, 32'h0);
        toggle0(5);
        readConst("edgecnt_five", BASE + 16, CNT_EN ? 32'd5 : 32'd0);
        toggle0(10);
        readConst("edgecnt_max", BASE + 16, CNT_EN ? 32'd15 : 32'd0);
        toggle0(1);
        readConst("edgecnt_wrap", BASE + 16, 32'd0);
        toggle0(2);
        pinV[0] = 1'b0;
        repeat (3) idle();
        pinV[0] = 1'b1;
        idle();
        idle();
        cycle(1'b1, 1'b0, BASE + 16, 32'h0);
        readConst("edgecnt_clear_wins", BASE + 16, 32'd0);

        drive(1'b1, 1'b0, BASE + 2, 32'hDEAD_BEEF);
        #1;
        chk("hit_misaligned", 32'(Hit), 32'h0);
        tick();
        drive(1'b1, 1'b0, BASE + 256, 32'h1234_5678);
        #1;
        chk("hit_outside", 32'(Hit), 32'h0);
        tick();
        cycle(1'b1, 1'b0, BASE + 4, 32'hFFFF_FFFF);
        chk("ignored_writes", PortOut, 32'hA5A5_0F0F);
        drive(1'b0, 1'b1, BASE + 32, 32'h0);
        #1;
        chk("unmapped_read", ReadData, 32'h0);
        chk("unmapped_hit", 32'(Hit), 32'h1);
        tick();

        cycle(1'b1, 1'b0, BASE, 32'h0000_00FF);
        chk("portout_ff", PortOut, 32'h0000_00FF);
        pinV = 8'h00;
        drive(1'b1, 1'b0, BASE, 32'h0000_1234);
        reset = 1'b0;
        #1;
        modelReset();
        chk("async_reset", PortOut, 32'h0);
        tick();
        chk("reset_write_dropped", PortOut, 32'h0);
        reset = 1'b1;
        idle();
        pinV = 8'h04;
        idle();
        idle();
        cycle(1'b1, 1'b0, BASE + 8, 32'h1);
        readConst("chg_set_wins", BASE + 8, 32'h1);

        for (int i = 0; i < 600; i++) begin
            int k;
            logic [31:0] a;
            k = $urandom_range(0, 9);
            if (k < 6) a = BASE + offs[k];
            else if (k == 6) a = BASE + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
            else if (k == 7) a = BASE + 256 + 4 * $urandom_range(0, 63);
            else if (k == 8) a = BASE + 4 * $urandom_range(0, 63);
            else a = BASE + 8;
            if ($urandom_range(0, 3) == 0) pinV = 8'($urandom);
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
        end

        MemWrite = 1'b0;
        MemRead = 1'b0;
        repeat (3) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
